// File: rtl/sensor_pkg.sv
// Shared constants and FSM encoding for the sensor transmitter and the
// arbiter-side receiver, so both ends are built from the same values.
package sensor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int         UART_CLOCK_BIT_DEFAULT = 5208;
   localparam logic [7:0] CRC_KEY_DEFAULT        = 8'h37;

endpackage

// File: rtl/sensor_tx_if.sv
// Sensor-side handshake and serial-line bundle for sensor_tx.
interface sensor_tx_if;

   logic [7:0] data_in;
   logic       valid;
   logic       ready;
   logic       tx;
   logic       busy;
   logic       done;

   modport master (
      output data_in, valid,
      input  ready, tx, busy, done
   );

   modport slave (
      input  data_in, valid,
      output ready, tx, busy, done
   );

endinterface

// File: rtl/crc8_calc.sv
// Combinational CRC-8 of one byte: MSB-first, init 0x00, no reflection,
// no final XOR.
module crc8_calc
   import sensor_pkg::*;
#(
   parameter logic [7:0] key = CRC_KEY_DEFAULT
) (
   input  logic [7:0] data,
   output logic [7:0] crc
);

   logic [7:0] acc;

   always_comb begin
      acc = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         if (acc[7] ^ data[i]) acc = {acc[6:0], 1'b0} ^ key;
         else                  acc = {acc[6:0], 1'b0};
      end
      crc = acc;
   end

endmodule

// File: rtl/sensor_tx.sv
// Accepts one sensor byte and sends it as two back-to-back UART 8N1 bytes:
// the reading followed by its CRC-8.
module sensor_tx
   import sensor_pkg::*;
#(
   parameter int         uart_clock_bit = UART_CLOCK_BIT_DEFAULT,
   parameter logic [7:0] key            = CRC_KEY_DEFAULT
) (
   input logic        clock,
   input logic        resetn,
   sensor_tx_if.slave bus
);

   localparam int               CNT_W    = (uart_clock_bit > 1) ? $clog2(uart_clock_bit) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(uart_clock_bit - 1);

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic             byte_sel;
   logic [7:0]       shift_reg;
   logic [7:0]       crc_reg;
   logic [7:0]       crc_next;
   logic             accept;
   logic             bit_end;

   crc8_calc #(.key(key)) u_crc (
      .data (bus.data_in),
      .crc  (crc_next)
   );

   assign accept  = bus.valid & bus.ready;
   assign bit_end = (baud_cnt == CNT_LAST);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= 3'd0;
         byte_sel  <= 1'b0;
         shift_reg <= 8'h00;
         crc_reg   <= 8'h00;
         bus.tx    <= 1'b1;
         bus.ready <= 1'b1;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= START;
                  byte_sel  <= 1'b0;
                  shift_reg <= bus.data_in;
                  crc_reg   <= crc_next;
                  baud_cnt  <= '0;
                  bit_idx   <= 3'd0;
                  bus.tx    <= 1'b0;
                  bus.ready <= 1'b0;
                  bus.busy  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt  <= '0;
                  state     <= DATA;
                  bus.tx    <= shift_reg[0];
                  shift_reg <= {1'b0, shift_reg[7:1]};
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= STOP;
                     bit_idx <= 3'd0;
                     bus.tx  <= 1'b1;
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     bus.tx    <= shift_reg[0];
                     shift_reg <= {1'b0, shift_reg[7:1]};
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  // Data byte's stop bit runs straight into the CRC byte's start bit.
                  if (!byte_sel) begin
                     state     <= START;
                     byte_sel  <= 1'b1;
                     shift_reg <= crc_reg;
                     bus.tx    <= 1'b0;
                  end else begin
                     state     <= IDLE;
                     bus.done  <= 1'b1;
                     bus.ready <= 1'b1;
                     bus.busy  <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sensor_tx.md
# sensor_tx

Sensor-side frame transmitter feeding the bus arbiter's UART receive pin. It accepts one 8-bit sensor reading through a valid/ready handshake and computes its CRC-8 with the system key. It then serializes two UART 8N1 bytes back-to-back on `tx`: data byte first, CRC byte second. The arbiter checks exactly this pair before exposing the byte to software.

## Interface
- `uart_clock_bit`, default 5208: clock cycles per UART bit (50 MHz / 9600 baud); legal range ≥ 2.
- `key`, default 8'b00110111: CRC-8 generator polynomial, implicit x^8 term.
- `clock`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  reset; one clock, reset is synchronous and active-low.
- `data_in`  in  8  sensor reading; sampled only on the accept cycle.
- `valid`  in  1  `data_in` is valid.
- `ready`  out  1  high only in IDLE; accept = `valid & ready` at a rising edge.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  frame in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse when the CRC byte's stop bit completes.

## Operation
- Reset values while `resetn`=0 at an edge: `tx`=1, `ready`=1, `busy`=0, `done`=0, state IDLE, all counters 0, holding registers 0.
- CRC-8 is MSB-first, init 0x00, no reflection, no final XOR. Computed on the 8-bit reading only.
- The CRC is computed combinationally from `data_in` on the accept cycle. It is registered together with the data byte.
- Byte format: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit holds `tx` for exactly `uart_clock_bit` cycles.
- FSM states: IDLE, START, DATA, STOP. A `byte_sel` flag selects the byte being sent: 0 = data, 1 = CRC.
- IDLE → START on accept; `byte_sel` := 0; data and CRC latched.
- START → DATA when the baud counter reaches `uart_clock_bit`-1.
- DATA: `bit_idx` runs 0..7. DATA → STOP after bit 7 completes its full bit time.
- STOP with `byte_sel`=0 → START with `byte_sel` := 1. No idle gap between the two bytes.
- STOP with `byte_sel`=1 → IDLE; `done`=1 on the edge entering IDLE.
- The baud counter resets to 0 on every bit boundary. `bit_idx` wraps 7 → 0 on leaving DATA.
- `valid` while not ready is ignored. No queueing. The source must hold `valid` until it sees `ready`.
- `data_in` changes after accept have no effect on the frame in flight.
- Reset mid-frame aborts immediately: `tx`=1 on the next edge, the frame is lost, and `done` is not pulsed.

## Timing
- Accept at edge E0 → `tx`=0, `busy`=1, `ready`=0 from E0 onward (registered outputs update at E0).
- Data byte start bit occupies cycles [E0, E0+N), where N = `uart_clock_bit`.
- Data bit k occupies [E0+(1+k)N, E0+(2+k)N).
- Data byte stop bit occupies [E0+9N, E0+10N).
- CRC byte occupies [E0+10N, E0+20N) with the same layout.
- At E0+20N: `done`=1 for one cycle, `busy`=0, `ready`=1, `tx`=1.
- A new accept is possible at edge E0+20N+1 at the earliest. Minimum frame period is 20N+1 cycles.
- `ready` is a pure state decode and has no combinational path from `valid`.

## Structure
- Shared package `sensor_pkg`:
  - state encoding (IDLE/START/DATA/STOP, 2 bits);
  - `UART_CLOCK_BIT_DEFAULT`=5208;
  - `CRC_KEY_DEFAULT`=8'h37.
- The same package constants parameterise the arbiter's instances so transmitter and checker cannot diverge.
- One sub-module: `crc8_calc` (combinational, parameter `key`, in `data[7:0]`, out `crc[7:0]`). It is reusable by the verification model.
- Top level holds the FSM, baud counter (width clog2(`uart_clock_bit`)), `bit_idx`, shift/holding registers and `byte_sel`.

## Test plan
All scenarios use `uart_clock_bit`=4.
- Reset then idle 50 cycles → `tx`=1, `ready`=1, `busy`=0, `done` never high.
- Accept `data_in`=0x01 → line carries 0x01 then CRC 0x37 (bits LSB-first, 4 cycles each); `done` pulse exactly 80 cycles after accept.
- Accept 0x80 → CRC byte 0x7F. Accept 0x00 → CRC 0x00. Accept 0x02 → CRC 0x6E. Each frame matches a reference UART decoder.
- Hold `valid`=1 with changing `data_in` throughout a frame → only the value at the accept edge is sent; next accept at accept+81.
- Assert `resetn`=0 during the DATA bit 3 of the CRC byte → `tx`=1 next edge, `busy`=0, no `done`; a fresh frame afterwards is correct.
- Loopback into the arbiter's receiver with 8 random readings → every received byte is reported with a passing checksum status.
